led_pattern_engine: RTL and testbench

- Parametrised successor to the LED shifter in the VIO/ILA debug top.
- Drives a moving or flashing pattern on N_LEDS mono LEDs, plus one selected RGB colour bank.
- Adds runtime-selectable modes (rotate, ping-pong, flash), four selectable tick rates, direction control, and button edge detection.
- Sits between the VIO probes (i_sw, i_btn, ck_rst) and the LED outputs, which are also probed by the ILA.

---
 rtl/led_pattern_pkg.sv | 34 +++
 rtl/btn_edge.sv | 60 ++++++
 rtl/led_pattern_engine.sv | 151 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode/colour/direction encodings and default tick limits for led_pattern_engine
package led_pattern_pkg;

  typedef enum logic [1:0] {
    SHIFT    = 2'd0,
    PINGPONG = 2'd1,
    FLASH    = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } colour_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pp_dir_t;

  localparam int unsigned DEF_LIMIT0 = 32'd1 << 23;
  localparam int unsigned DEF_LIMIT1 = 32'd1 << 24;
  localparam int unsigned DEF_LIMIT2 = 32'd1 << 25;
  localparam int unsigned DEF_LIMIT3 = 32'd1 << 26;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      SHIFT:    return PINGPONG;
      PINGPONG: return FLASH;
      default:  return SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - per-button sync register, optional debounce filter (BTN_DEBOUNCE_EN), rising-edge pulse
module btn_edge
`ifdef BTN_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = 16
)
`endif
(
  input  logic clock,
  input  logic ck_rst,
  input  logic btn,
  output logic pulse
);

  logic sync_q;
  logic level;
  logic level_d;

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= btn;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] stable_cnt;

  // The filtered level only follows the synchronised input once it has disagreed for DEB_CYCLES in a row.
  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_q == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
      level      <= sync_q;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign level = sync_q;
`endif

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - rotate/ping-pong/flash LED pattern with rate, direction and RGB bank select; BTN_DEBOUNCE_EN adds button filtering
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int          N_LEDS     = 4,
  parameter int          NB_COUNT   = 32,
  parameter int          NB_SW      = 4,
  parameter int          NB_BTN     = 4,
  parameter int unsigned LIMIT0     = DEF_LIMIT0,
  parameter int unsigned LIMIT1     = DEF_LIMIT1,
  parameter int unsigned LIMIT2     = DEF_LIMIT2,
  parameter int unsigned LIMIT3     = DEF_LIMIT3,
  parameter int          DEB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              ck_rst,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_led_r,
  output logic [N_LEDS-1:0] o_led_g,
  output logic [N_LEDS-1:0] o_led_b
);

  if (N_LEDS < 2 || NB_SW < 4 || NB_BTN < 4 || DEB_CYCLES < 1) begin : g_param_check
    $error("led_pattern_engine: illegal parameter set");
  end

  logic [NB_BTN-1:0] btn_pulse;

  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_edge
`ifdef BTN_DEBOUNCE_EN
      #(.DEB_CYCLES(DEB_CYCLES))
`endif
      u_btn_edge (
        .clock  (clock),
        .ck_rst (ck_rst),
        .btn    (i_btn[i]),
        .pulse  (btn_pulse[i])
      );
  end

  logic [NB_COUNT-1:0] cnt;
  logic [NB_COUNT-1:0] limit_m1;
  logic                run;
  logic                tick;

  mode_t               mode;
  colour_t             colour;
  colour_t             colour_nxt;
  pp_dir_t             pp_dir;
  pp_dir_t             pp_dir_nxt;
  logic [N_LEDS-1:0]   pattern;
  logic [N_LEDS-1:0]   pattern_nxt;

  always_comb begin
    limit_m1 = NB_COUNT'(LIMIT0 - 1);
    case (i_sw[2:1])
      2'd0:    limit_m1 = NB_COUNT'(LIMIT0 - 1);
      2'd1:    limit_m1 = NB_COUNT'(LIMIT1 - 1);
      2'd2:    limit_m1 = NB_COUNT'(LIMIT2 - 1);
      default: limit_m1 = NB_COUNT'(LIMIT3 - 1);
    endcase
  end

  assign run = i_sw[0];
  // >= rather than == so a switch to a shorter rate mid-count ticks at once instead of wrapping.
  assign tick = run && (cnt >= limit_m1);

  always_comb begin
    pattern_nxt = pattern;
    pp_dir_nxt  = pp_dir;
    if (btn_pulse[0]) begin
      pp_dir_nxt  = DIR_UP;
      pattern_nxt = (next_mode(mode) == FLASH) ? '1 : N_LEDS'(1);
    end else if (tick) begin
      case (mode)
        SHIFT: begin
          if (i_sw[3]) begin
            pattern_nxt = {pattern[0], pattern[N_LEDS-1:1]};
          end else begin
            pattern_nxt = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
          end
        end
        PINGPONG: begin
          if (pp_dir == DIR_UP) begin
            if (pattern[N_LEDS-1]) begin
              pattern_nxt = pattern >> 1;
              pp_dir_nxt  = DIR_DOWN;
            end else begin
              pattern_nxt = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pattern_nxt = pattern << 1;
              pp_dir_nxt  = DIR_UP;
            end else begin
              pattern_nxt = pattern >> 1;
            end
          end
        end
        FLASH:   pattern_nxt = (pattern == '1) ? '0 : '1;
        default: pattern_nxt = N_LEDS'(1);
      endcase
    end
  end

  // Lowest button index wins when several colour edges land together.
  always_comb begin
    colour_nxt = colour;
    if (btn_pulse[1]) begin
      colour_nxt = COL_R;
    end else if (btn_pulse[2]) begin
      colour_nxt = COL_G;
    end else if (btn_pulse[3]) begin
      colour_nxt = COL_B;
    end
  end

  always_ff @(posedge clock or negedge ck_rst) begin
    if (!ck_rst) begin
      cnt     <= '0;
      mode    <= SHIFT;
      colour  <= COL_R;
      pp_dir  <= DIR_UP;
      pattern <= N_LEDS'(1);
      o_led_r <= N_LEDS'(1);
      o_led_g <= '0;
      o_led_b <= '0;
    end else begin
      pattern <= pattern_nxt;
      pp_dir  <= pp_dir_nxt;
      colour  <= colour_nxt;
      o_led_r <= (colour_nxt == COL_R) ? pattern_nxt : '0;
      o_led_g <= (colour_nxt == COL_G) ? pattern_nxt : '0;
      o_led_b <= (colour_nxt == COL_B) ? pattern_nxt : '0;
      if (btn_pulse[0]) begin
        mode <= next_mode(mode);
        cnt  <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_led = pattern;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed scoreboard bench for led_pattern_engine (extra glitch steps with BTN_DEBOUNCE_EN)
`timescale 1ns/1ps
module tb_led_pattern_engine;

  localparam int N = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int PRESS  = 6;
  localparam int SETTLE = 10;
`else
  localparam int PRESS  = 1;
  localparam int SETTLE = 3;
`endif

  logic         clock = 1'b0;
  logic         ck_rst;
  logic [3:0]   i_sw;
  logic [3:0]   i_btn;
  logic [N-1:0] o_led;
  logic [N-1:0] o_led_r;
  logic [N-1:0] o_led_g;
  logic [N-1:0] o_led_b;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_exp;
  logic [N-1:0] prev_led;
  logic [N-1:0] exp_v;

  always #5 clock = ~clock;

  led_pattern_engine #(
    .N_LEDS     (N),
    .NB_COUNT   (32),
    .NB_SW      (4),
    .NB_BTN     (4),
    .LIMIT0     (4),
    .LIMIT1     (8),
    .LIMIT2     (16),
    .LIMIT3     (32),
    .DEB_CYCLES (4)
  ) dut (
    .clock   (clock),
    .ck_rst  (ck_rst),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_led_r (o_led_r),
    .o_led_g (o_led_g),
    .o_led_b (o_led_b)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] p);
    if (p !== last_exp) begin
      exp_q.push_back(p);
      last_exp = p;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] mask);
    i_btn = mask;
    cycles(PRESS);
    i_btn = 4'b0000;
    cycles(SETTLE);
  endtask

  // Every visible o_led change out of reset must match the next queued pattern.
  always @(negedge clock) begin
    if (ck_rst === 1'b1 && o_led !== prev_led) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_extra observed=%b expected=none", o_led);
      end else begin
        exp_v = exp_q.pop_front();
        check("scoreboard", o_led, exp_v);
      end
    end
    prev_led = o_led;
  end

  initial begin
    ck_rst   = 1'b0;
    i_sw     = 4'b0000;
    i_btn    = 4'b0000;
    last_exp = 4'b0001;
    cycles(3);
    check("reset_led", o_led, 4'b0001);
    check("reset_r", o_led_r, 4'b0001);
    check("reset_g", o_led_g, 4'b0000);
    check("reset_b", o_led_b, 4'b0000);

    // SHIFT left at rate 0, then right
    push_exp(4'b0010); push_exp(4'b0100); push_exp(4'b1000); push_exp(4'b0001);
    i_sw   = 4'b0001;
    ck_rst = 1'b1;
    cycles(3);
    check("first_tick_hold", o_led, 4'b0001);
    cycles(1);
    check("first_tick", o_led, 4'b0010);
    cycles(12);
    i_sw = 4'b1001;
    push_exp(4'b1000); push_exp(4'b0100);
    cycles(8);

    // PINGPONG bounces regardless of i_sw[3]
    i_sw = 4'b1000;
    push_exp(4'b0001);
    press(4'b0001);
    i_sw = 4'b1001;
    push_exp(4'b0010); push_exp(4'b0100); push_exp(4'b1000); push_exp(4'b0100);
    push_exp(4'b0010); push_exp(4'b0001); push_exp(4'b0010);
    cycles(28);
    check("pingpong_end", o_led, 4'b0010);

    // FLASH
    i_sw = 4'b1000;
    push_exp(4'b1111);
    press(4'b0001);
    i_sw = 4'b0001;
    push_exp(4'b0000); push_exp(4'b1111);
    cycles(8);
    i_sw = 4'b0000;

    // G and B together: G wins, holding gives nothing more
    i_btn = 4'b1100;
    cycles(SETTLE);
    check("colour_g", o_led_g, 4'b1111);
    check("colour_g_r", o_led_r, 4'b0000);
    check("colour_g_b", o_led_b, 4'b0000);
    cycles(20);
    check("colour_hold_g", o_led_g, 4'b1111);
    check("colour_hold_led", o_led, 4'b1111);
    i_btn = 4'b0000;
    cycles(SETTLE);

    // Frozen while disabled, then rate 1 -> 0 switch at cnt = 6
    cycles(50);
    check("freeze", o_led, 4'b1111);
    i_sw = 4'b0011;
    cycles(6);
    i_sw = 4'b0001;
    push_exp(4'b0000);
    cycles(1);
    check("rate_switch_tick", o_led, 4'b0000);
    cycles(3);
    check("rate0_hold", o_led, 4'b0000);
    push_exp(4'b1111);
    cycles(1);
    check("rate0_spacing", o_led, 4'b1111);
    i_sw = 4'b0000;

    // PINGPONG with B, then async reset mid-run
    push_exp(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b1000);
    i_sw = 4'b0001;
    push_exp(4'b0010); push_exp(4'b0100);
    cycles(8);
    check("bank_b", o_led_b, 4'b0100);
    check("bank_b_r", o_led_r, 4'b0000);
    check("bank_b_g", o_led_g, 4'b0000);
    #2 ck_rst = 1'b0;
    #1;
    check("async_led", o_led, 4'b0001);
    check("async_r", o_led_r, 4'b0001);
    check("async_g", o_led_g, 4'b0000);
    check("async_b", o_led_b, 4'b0000);
    last_exp = 4'b0001;
    cycles(2);
    push_exp(4'b0010);
    ck_rst = 1'b1;
    cycles(4);
    check("post_reset_r", o_led_r, 4'b0010);

`ifdef BTN_DEBOUNCE_EN
    i_sw  = 4'b0000;
    i_btn = 4'b0001;
    cycles(2);
    i_btn = 4'b0000;
    cycles(12);
    check("glitch_ignored", o_led, 4'b0010);
    push_exp(4'b0001);
    i_btn = 4'b0001;
    cycles(6);
    i_btn = 4'b0000;
    cycles(12);
    check("debounced_press", o_led, 4'b0001);
`endif

    cycles(2);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drained observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
